// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared modes, directions and state encoding for the shift sequencer
package shift_seq_pkg;
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_ROTATE  = 2'b01;
  localparam logic [1:0] MODE_BOUNCE  = 2'b10;
  localparam logic [1:0] MODE_CLEAR   = 2'b11;
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
endpackage

// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if: control/feedback link between the sequencer and the shift register
interface shift_seq_ctrl_if #(parameter int SHLEN = 6);
  logic SH_EN, SH_DIR, SH_IN;
  logic [SHLEN-1:0] SH_Q;
  modport master(output SH_EN, SH_DIR, SH_IN, input SH_Q);
  modport slave(input SH_EN, SH_DIR, SH_IN, output SH_Q);
endinterface

// File: rtl/tick_gen.sv
// tick_gen: prescaler counting 0..TICK_DIV-1 with sync clear/enable and a registered wrap pulse
module tick_gen #(
  parameter int TICK_DIV = 25000000,
  parameter int CW = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic wrap,
  output logic tick
);
  logic [CW-1:0] cnt;
  assign wrap = en && cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk)
    if (rst || clr) begin
      cnt <= '0;
      tick <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : en ? cnt + 1'b1 : cnt;
      tick <= wrap;
    end
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: loads a pattern serially into a shift register, then optionally rotates or bounces it
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int SHLEN = 6,
  parameter int TICK_DIV = 25000000,
  parameter int CW = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
  input  logic             PAUSE,
  input  logic [1:0]       MODE,
  input  logic             DIR_CFG,
  input  logic [SHLEN-1:0] PAT,
  shift_seq_ctrl_if.master sh,
  output logic             TICK,
  output logic             BUSY,
  output logic             DONE,
  output logic [7:0]       STEP_CNT
);
  localparam int IW = $clog2(SHLEN);
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [7:0] step_n;
  logic [1:0] mode_q, mode_n;
  logic [SHLEN-1:0] pat_q, pat_n;
  logic en_q, en_n, in_q, in_n, done_n, dir_q, dir_n, flip_q, flip_n;
  logic wrap, go, last, load_bit, rot_bit;
  assign BUSY = state != IDLE;
  assign go = state == IDLE && START && !STOP;
  assign last = idx == IW'(SHLEN - 1);
  assign load_bit = mode_q == MODE_CLEAR ? 1'b0 : dir_q == DIR_LEFT ? pat_q[IW'(SHLEN - 1) - idx] : pat_q[idx];
  assign rot_bit = dir_q == DIR_LEFT ? sh.SH_Q[SHLEN-1] : sh.SH_Q[0];
  assign sh.SH_EN = en_q;
  assign sh.SH_IN = in_q;
  assign sh.SH_DIR = dir_q;
  tick_gen #(.TICK_DIV(TICK_DIV), .CW(CW)) u_tick (
    .clk(CLK), .rst(RST), .clr(go), .en(BUSY && !PAUSE && !STOP), .wrap(wrap), .tick(TICK)
  );
  // A LOAD cycle with en_q set and idx back at 0 is the one right after the final oneshot/clear step
  always_comb begin
    state_n = state;
    idx_n = idx;
    step_n = STEP_CNT;
    en_n = 1'b0;
    in_n = 1'b0;
    done_n = 1'b0;
    dir_n = flip_q ? ~dir_q : dir_q;
    flip_n = 1'b0;
    mode_n = mode_q;
    pat_n = pat_q;
    if (go) begin
      state_n = LOAD;
      idx_n = '0;
      step_n = '0;
      mode_n = MODE;
      pat_n = PAT;
      dir_n = DIR_CFG;
    end else if (BUSY && STOP) begin
      state_n = IDLE;
    end else if (state == LOAD && en_q && idx == '0) begin
      state_n = IDLE;
      done_n = 1'b1;
    end else if (wrap) begin
      en_n = 1'b1;
      step_n = STEP_CNT + 8'd1;
      idx_n = last ? '0 : idx + 1'b1;
      in_n = state == LOAD ? load_bit : rot_bit;
      flip_n = state == RUN && last && mode_q == MODE_BOUNCE;
      if (state == LOAD && last && (mode_q == MODE_ROTATE || mode_q == MODE_BOUNCE)) state_n = RUN;
    end
  end
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      idx <= '0;
      STEP_CNT <= '0;
      en_q <= 1'b0;
      in_q <= 1'b0;
      DONE <= 1'b0;
      dir_q <= 1'b0;
      flip_q <= 1'b0;
      mode_q <= MODE_ONESHOT;
      pat_q <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      STEP_CNT <= step_n;
      en_q <= en_n;
      in_q <= in_n;
      DONE <= done_n;
      dir_q <= dir_n;
      flip_q <= flip_n;
      mode_q <= mode_n;
      pat_q <= pat_n;
    end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: randomized scenarios checked against a cycle-count/pattern reference model
module tb_shift_seq_ctrl;
  import shift_seq_pkg::*;
  localparam int SHLEN = 6;
  localparam int TD = 4;
  logic clk = 0, rst = 0, start = 0, stop = 0, pause = 0, dir_cfg = 0, ld = 0;
  logic tick, busy, done;
  logic [1:0] mode = 0;
  logic [5:0] pat = 0, sreg, ld_val = 0;
  logic [7:0] step_cnt;
  int errs = 0, checks = 0;
  shift_seq_ctrl_if #(.SHLEN(SHLEN)) sh ();
  shift_seq_ctrl #(.SHLEN(SHLEN), .TICK_DIV(TD), .CW(8)) dut (
    .CLK(clk), .RST(rst), .START(start), .STOP(stop), .PAUSE(pause), .MODE(mode),
    .DIR_CFG(dir_cfg), .PAT(pat), .sh(sh), .TICK(tick), .BUSY(busy), .DONE(done), .STEP_CNT(step_cnt)
  );
  always #5 clk = ~clk;
  // the attached shift register: left puts IN at bit 0, right puts IN at the MSB
  always @(posedge clk)
    if (ld) sreg <= ld_val;
    else if (sh.SH_EN) sreg <= sh.SH_DIR ? {sreg[4:0], sh.SH_IN} : {sh.SH_IN, sreg[5:1]};
  assign sh.SH_Q = sreg;

  function automatic logic [5:0] rot(input logic [5:0] x, input logic left);
    return left ? (x << 1) | (x >> 5) : (x >> 1) | (x << 5);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input logic [5:0] v);
    ld = 1; ld_val = v; cyc(); ld = 0;
  endtask

  task automatic test_reset();
    logic [13:0] got;
    rst = 1; cyc(); cyc();
    got = {sh.SH_EN, sh.SH_DIR, sh.SH_IN, tick, busy, done, step_cnt};
    checks++;
    if (got !== 14'b0) begin errs++; $display("FAIL reset outputs got=%b want=0", got); end
    rst = 0; cyc();
  endtask

  // oneshot/clear load; optional 10-cycle pause starting after cycle ps, optional START while busy at cycle sp
  task automatic test_load(input logic [5:0] p, input logic d, input logic [1:0] m, input int ps, input int sp);
    int act = 0, nst = 0;
    logic live = 1, pz, en, ein, edone;
    logic [5:0] got, want;
    preset(6'($urandom));
    pat = p; dir_cfg = d; mode = m; start = 1; cyc(); start = 0;
    for (int c = 1; c <= 45; c++) begin
      pz = c > ps && c <= ps + 10;
      pause = pz;
      if (c == sp) begin start = 1; pat = ~p; dir_cfg = ~d; mode = ~m; end
      en = 0; ein = 0; edone = 0;
      if (live && nst == SHLEN) begin edone = 1; live = 0; end
      else if (live && !pz) begin act++; en = act % TD == 0; end
      if (en) begin ein = m == MODE_CLEAR ? 1'b0 : d ? p[SHLEN-1-nst] : p[nst]; nst++; end
      cyc();
      start = 0;
      got = {sh.SH_EN, sh.SH_IN, tick, done, busy, sh.SH_DIR};
      want = {en, ein, en, edone, live, d};
      checks++;
      if (got !== want) begin errs++; $display("FAIL load c=%0d en/in/tick/done/busy/dir got=%b want=%b", c, got, want); end
      checks++;
      if (step_cnt !== 8'(nst)) begin errs++; $display("FAIL load_stepcnt c=%0d got=%0d want=%0d", c, step_cnt, nst); end
    end
    pause = 0;
    want = m == MODE_CLEAR ? 6'b0 : p;
    checks++;
    if (sreg !== want) begin errs++; $display("FAIL load_final reg got=%b want=%b", sreg, want); end
  endtask

  // rotate/bounce for nrun RUN steps, then STOP
  task automatic test_run(input logic [5:0] p, input logic d, input logic [1:0] m, input int nrun);
    logic [5:0] cur;
    logic en, ein, ed, bad;
    int k, j;
    preset(6'($urandom));
    pat = p; dir_cfg = d; mode = m; start = 1; cyc(); start = 0;
    cur = p;
    for (int c = 1; c <= TD * (SHLEN + nrun); c++) begin
      k = c / TD; en = c % TD == 0; ein = 0; ed = d;
      if (en && k <= SHLEN) ein = d ? p[SHLEN-k] : p[k-1];
      else if (en) begin
        j = k - SHLEN;
        ed = m == MODE_BOUNCE ? d ^ (((j - 1) / SHLEN) % 2 == 1) : d;
        ein = ed ? cur[5] : cur[0];
        cur = rot(cur, ed);
      end
      cyc();
      checks++;
      if ({sh.SH_EN, sh.SH_IN, tick, done, busy} !== {en, ein, en, 1'b0, 1'b1}) begin
        errs++; $display("FAIL run c=%0d en/in/tick/done/busy got=%b want=%b", c, {sh.SH_EN, sh.SH_IN, tick, done, busy}, {en, ein, en, 1'b0, 1'b1});
      end
      if (en) begin
        checks++;
        if (sh.SH_DIR !== ed) begin errs++; $display("FAIL run_dir c=%0d got=%b want=%b", c, sh.SH_DIR, ed); end
        checks++;
        if (step_cnt !== 8'(k)) begin errs++; $display("FAIL run_stepcnt c=%0d got=%0d want=%0d", c, step_cnt, k); end
      end
      if (c % TD == 1 && c > TD * SHLEN) begin
        checks++;
        if (sreg !== cur) begin errs++; $display("FAIL run_reg c=%0d got=%b want=%b", c, sreg, cur); end
      end
    end
    stop = 1; cyc(); stop = 0;
    checks++;
    if ({sh.SH_EN, done, busy} !== 3'b0) begin errs++; $display("FAIL run_stop en/done/busy got=%b want=000", {sh.SH_EN, done, busy}); end
    bad = 0;
    repeat (6) begin cyc(); bad |= sh.SH_EN | done | busy; end
    checks++;
    if (bad !== 1'b0 || sreg !== cur) begin errs++; $display("FAIL run_after_stop activity=%b reg got=%b want=%b", bad, sreg, cur); end
  endtask

  task automatic test_stop_start_idle();
    logic bad = 0;
    pat = 6'($urandom); mode = MODE_ONESHOT; start = 1; stop = 1; cyc(); start = 0; stop = 0;
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL stop_start busy got=%b want=0", busy); end
    repeat (8) begin cyc(); bad |= sh.SH_EN | busy | done; end
    checks++;
    if (bad !== 1'b0) begin errs++; $display("FAIL stop_start activity got=%b want=0", bad); end
  endtask

  // STOP on the edge that would otherwise issue the third step
  task automatic test_stop_load(input logic [5:0] p, input logic d);
    logic [5:0] r0, want;
    logic bad = 0;
    r0 = 6'($urandom);
    preset(r0);
    pat = p; dir_cfg = d; mode = MODE_ONESHOT; start = 1; cyc(); start = 0;
    repeat (3 * TD - 1) cyc();
    stop = 1; cyc(); stop = 0;
    checks++;
    if ({sh.SH_EN, sh.SH_IN, tick, done, busy} !== 5'b0) begin
      errs++; $display("FAIL stop_load en/in/tick/done/busy got=%b want=00000", {sh.SH_EN, sh.SH_IN, tick, done, busy});
    end
    checks++;
    if (step_cnt !== 8'd2) begin errs++; $display("FAIL stop_load_stepcnt got=%0d want=2", step_cnt); end
    repeat (6) begin cyc(); bad |= sh.SH_EN | done | busy; end
    want = d ? (r0 << 2) | (p >> 4) : (r0 >> 2) | (p << 4);
    checks++;
    if (bad !== 1'b0 || sreg !== want) begin errs++; $display("FAIL stop_load_after activity=%b reg got=%b want=%b", bad, sreg, want); end
  endtask

  task automatic test_reset_mid();
    logic [13:0] got;
    pat = 6'($urandom); dir_cfg = 1; mode = MODE_ROTATE; start = 1; cyc(); start = 0;
    repeat (10) cyc();
    rst = 1; cyc();
    got = {sh.SH_EN, sh.SH_DIR, sh.SH_IN, tick, busy, done, step_cnt};
    checks++;
    if (got !== 14'b0) begin errs++; $display("FAIL reset_mid outputs got=%b want=0", got); end
    rst = 0;
    repeat (TD * 2) cyc();
    checks++;
    if ({busy, done, sh.SH_EN} !== 3'b0) begin errs++; $display("FAIL reset_mid_after busy/done/en got=%b want=000", {busy, done, sh.SH_EN}); end
  endtask

  initial begin
    test_reset();
    test_load(6'b101100, 1'b1, MODE_ONESHOT, -100, -1);
    test_load(6'b101100, 1'b0, MODE_ONESHOT, -100, -1);
    test_load(6'($urandom), 1'($urandom), MODE_CLEAR, -100, -1);
    test_load(6'($urandom), 1'($urandom), MODE_ONESHOT, $urandom_range(5, 15), -1);
    test_load(6'($urandom), 1'($urandom), MODE_ONESHOT, -100, $urandom_range(2, 20));
    test_load(6'($urandom), 1'($urandom), MODE_CLEAR, $urandom_range(5, 15), $urandom_range(2, 20));
    test_run(6'b000001, 1'b1, MODE_ROTATE, 6);
    test_run(6'($urandom), 1'b0, MODE_ROTATE, 8);
    test_run(6'b000001, 1'b1, MODE_BOUNCE, 18);
    test_run(6'($urandom), 1'($urandom), MODE_BOUNCE, 14);
    test_stop_start_idle();
    test_stop_load(6'($urandom), 1'b1);
    test_stop_load(6'($urandom), 1'b0);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
